// File: rtl/spike_event_scheduler.sv
// Sequencer for the time-multiplexed neuron core: queues spike events and runs one accumulate
// sweep per event, then one leak/fire update sweep per timestep over all neurons.
module spike_event_scheduler #(
    parameter int unsigned NR_DEPTH         = 16,
    parameter int unsigned SR_DEPTH         = 16384,
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter int unsigned MAX_NETWORK_TIME = 65536
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                start_i,
    input  logic                                step_i,
    input  logic                                input_occurred_i,
    input  logic [$clog2(SR_DEPTH)-1:0]         input_index_i,
    output logic                                input_ack_o,
    output logic [$clog2(NR_DEPTH)-1:0]         c_neuron_index_o,
    output logic [$clog2(SR_DEPTH)-1:0]         c_synapse_index_o,
    output logic                                c_neuron_we_o,
    output logic                                c_accumulate_o,
    output logic                                fire_valid_o,
    output logic [$clog2(MAX_NETWORK_TIME)-1:0] timestep_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                step_overrun_o
);
    localparam int unsigned NW = $clog2(NR_DEPTH);
    localparam int unsigned SW = $clog2(SR_DEPTH);
    localparam int unsigned TW = $clog2(MAX_NETWORK_TIME);
    localparam int unsigned FW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = FW + 1;
    localparam logic [NW-1:0] LastNeuron = NW'(NR_DEPTH - 1);
    localparam logic [TW-1:0] LastStep   = TW'(MAX_NETWORK_TIME - 1);
    localparam logic [CW-1:0] FifoFull   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StWait, StAccRd, StAccWr, StUpdRd, StUpdWr, StDone
    } state_e;

    state_e         state_q;
    logic [NW-1:0]  neuron_q;
    logic [SW-1:0]  event_q;
    logic [TW-1:0]  timestep_q;
    logic           pending_q;
    logic           overrun_q;
    logic [SW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]  wr_ptr_q;
    logic [FW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    logic running, fifo_full, fifo_empty, push, pop, take_step, start_run, last_neuron;

    always_comb begin
        running     = (state_q != StIdle) && (state_q != StDone);
        fifo_full   = (count_q == FifoFull);
        fifo_empty  = (count_q == '0);
        push        = input_occurred_i && !fifo_full && running;
        pop         = (state_q == StWait) && !fifo_empty;
        // Queued events always go before the update pass of the same timestep.
        take_step   = (state_q == StWait) && fifo_empty && pending_q;
        start_run   = start_i && !running;
        last_neuron = (neuron_q == LastNeuron);
    end

    assign input_ack_o = push;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= input_index_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            neuron_q   <= '0;
            event_q    <= '0;
            timestep_q <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (start_run) begin
                // A new run discards anything left queued from the previous one.
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                timestep_q <= '0;
                pending_q  <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
                if (step_i && pending_q) overrun_q <= 1'b1;
                pending_q <= take_step ? 1'b0 : (pending_q | step_i);
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (start_run) state_q <= StWait;
                end
                StWait: begin
                    if (pop) begin
                        event_q  <= fifo_mem[rd_ptr_q];
                        neuron_q <= '0;
                        state_q  <= StAccRd;
                    end else if (take_step) begin
                        neuron_q <= '0;
                        state_q  <= StUpdRd;
                    end
                end
                StAccRd: state_q <= StAccWr;
                StAccWr: begin
                    if (last_neuron) begin
                        state_q <= StWait;
                    end else begin
                        neuron_q <= neuron_q + 1'b1;
                        state_q  <= StAccRd;
                    end
                end
                StUpdRd: state_q <= StUpdWr;
                StUpdWr: begin
                    if (!last_neuron) begin
                        neuron_q <= neuron_q + 1'b1;
                        state_q  <= StUpdRd;
                    end else if (timestep_q == LastStep) begin
                        state_q <= StDone;
                    end else begin
                        timestep_q <= timestep_q + 1'b1;
                        state_q    <= StWait;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        c_neuron_index_o  = '0;
        c_synapse_index_o = '0;
        c_neuron_we_o     = 1'b0;
        c_accumulate_o    = 1'b0;
        fire_valid_o      = 1'b0;
        done_o            = 1'b0;
        unique case (state_q)
            StAccRd, StAccWr: begin
                c_accumulate_o    = 1'b1;
                c_synapse_index_o = event_q;
                c_neuron_index_o  = neuron_q;
                c_neuron_we_o     = (state_q == StAccWr);
            end
            StUpdRd: c_neuron_index_o = neuron_q;
            StUpdWr: begin
                c_neuron_index_o = neuron_q;
                c_neuron_we_o    = 1'b1;
                fire_valid_o     = 1'b1;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o         = running;
    assign timestep_o     = timestep_q;
    assign step_overrun_o = overrun_q;
endmodule

// File: tb/tb_spike_event_scheduler.sv
// Bench for spike_event_scheduler: a phase/queue model of the sequencer is compared with every
// output each cycle, alongside hand-computed checks of the key latencies and counts.
module tb_spike_event_scheduler;
    localparam int NR   = 16;
    localparam int FD   = 8;
    localparam int MAXT = 4;

    logic        clk_i   = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        step_i  = 1'b0;
    logic        occ     = 1'b0;
    logic [13:0] idx     = '0;
    logic        input_ack_o, c_neuron_we_o, c_accumulate_o, fire_valid_o;
    logic        busy_o, done_o, step_overrun_o;
    logic [3:0]  c_neuron_index_o;
    logic [13:0] c_synapse_index_o;
    logic [1:0]  timestep_o;

    spike_event_scheduler #(
        .NR_DEPTH        (NR),
        .SR_DEPTH        (16384),
        .FIFO_DEPTH      (FD),
        .MAX_NETWORK_TIME(MAXT)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .step_i           (step_i),
        .input_occurred_i (occ),
        .input_index_i    (idx),
        .input_ack_o      (input_ack_o),
        .c_neuron_index_o (c_neuron_index_o),
        .c_synapse_index_o(c_synapse_index_o),
        .c_neuron_we_o    (c_neuron_we_o),
        .c_accumulate_o   (c_accumulate_o),
        .fire_valid_o     (fire_valid_o),
        .timestep_o       (timestep_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .step_overrun_o   (step_overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int fire_cnt = 0;
    int acc5_cnt = 0;
    int dut_ev[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Model: mode 0 idle, 1 wait, 2 accumulate sweep, 3 update sweep, 4 done;
    // m_pos counts the 2*NR cycles of a sweep.
    int m_mode, m_pos, m_ev, m_ts;
    bit m_pend, m_ovr;
    int m_q[$];

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_pos = 0; m_ev = 0; m_ts = 0; m_pend = 0; m_ovr = 0;
        m_q.delete();
    endfunction

    function automatic bit m_run();
        return m_mode >= 1 && m_mode <= 3;
    endfunction

    function automatic void model_step();
        bit ack, take;
        ack = occ && m_q.size() < FD && m_run();
        if (start_i && !m_run()) begin
            m_q.delete(); m_ts = 0; m_pend = 0; m_ovr = 0; m_mode = 1; m_pos = 0;
            return;
        end
        if (step_i && m_pend) m_ovr = 1;
        take = (m_mode == 1) && (m_q.size() == 0) && m_pend;
        m_pend = take ? 1'b0 : (m_pend | step_i);
        case (m_mode)
            1: begin
                if (m_q.size() > 0) begin
                    m_ev = m_q.pop_front(); m_mode = 2; m_pos = 0;
                end else if (take) begin
                    m_mode = 3; m_pos = 0;
                end
            end
            2: if (m_pos == 2*NR-1) m_mode = 1; else m_pos++;
            3: begin
                if (m_pos != 2*NR-1) m_pos++;
                else if (m_ts == MAXT-1) m_mode = 4;
                else begin m_ts++; m_mode = 1; end
            end
            default: ;
        endcase
        if (ack) m_q.push_back(int'(idx));
    endfunction

    initial begin
        bit acc, upd;
        model_reset();
        forever begin
            @(negedge clk_i);
            #2;
            if (reset_i) model_reset();
            acc = (m_mode == 2);
            upd = (m_mode == 3);
            chk("input_ack", int'(input_ack_o), int'(occ && m_q.size() < FD && m_run()));
            chk("c_accumulate", int'(c_accumulate_o), int'(acc));
            chk("c_synapse_index", int'(c_synapse_index_o), acc ? m_ev : 0);
            chk("c_neuron_index", int'(c_neuron_index_o), (acc || upd) ? m_pos / 2 : 0);
            chk("c_neuron_we", int'(c_neuron_we_o), int'((acc || upd) && m_pos % 2 == 1));
            chk("fire_valid", int'(fire_valid_o), int'(upd && m_pos % 2 == 1));
            chk("busy", int'(busy_o), int'(m_run()));
            chk("done", int'(done_o), int'(m_mode == 4));
            chk("timestep", int'(timestep_o), m_ts);
            chk("step_overrun", int'(step_overrun_o), int'(m_ovr));
            if (fire_valid_o) fire_cnt++;
            if (c_accumulate_o && c_synapse_index_o == 14'd5) acc5_cnt++;
            if (c_accumulate_o && !c_neuron_we_o && c_neuron_index_o == 4'd0)
                dut_ev.push_back(int'(c_synapse_index_o));
            @(posedge clk_i);
            if (reset_i) model_reset(); else model_step();
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk_i);
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic pulse_step();
        step_i = 1'b1;
        @(negedge clk_i);
        step_i = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting cycle.
    task automatic send(input int i, input int budget, output int t_ack);
        occ = 1'b1;
        idx = 14'(i);
        t_ack = -1;
        for (int k = 0; k < budget; k++) begin
            #1;
            if (input_ack_o) t_ack = cyc;
            @(negedge clk_i);
            if (t_ack >= 0) break;
        end
        occ = 1'b0;
        if (t_ack < 0) begin
            tests++; fails++;
            $display("FAIL ack_timeout: got no ack, required ack within %0d cycles", budget);
        end
    endtask

    initial begin
        int s, a, k;
        int t[10];
        int ev[10];
        bit acked;
        #1 reset_i = 1'b1;
        occ = 1'b1; idx = 14'd7;
        repeat (3) @(negedge clk_i);
        settle();
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ack", int'(input_ack_o), 0);
        chk("rst_done", int'(done_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0; occ = 1'b0;
        @(negedge clk_i);

        // Step with no events: update pass timing
        s = cyc;
        pulse_start();
        goto(s + 10);
        pulse_step();
        fire_cnt = 0;
        @(negedge clk_i); settle();
        chk("upd_rd_fire", int'(fire_valid_o), 0);
        chk("upd_rd_busy", int'(busy_o), 1);
        @(negedge clk_i); settle();
        chk("upd_wr0_fire", int'(fire_valid_o), 1);
        chk("upd_wr0_index", int'(c_neuron_index_o), 0);
        goto(s + 43); settle();
        chk("ts_before_end", int'(timestep_o), 0);
        goto(s + 44); settle();
        chk("ts_after_end", int'(timestep_o), 1);
        chk("fire_count_1", fire_cnt, 16);

        // Single event, index 5
        acc5_cnt = 0;
        send(5, 10, a);
        settle();
        chk("acc_lat_wait", int'(c_accumulate_o), 0);
        goto(a + 2); settle();
        chk("acc_lat_rd", int'(c_accumulate_o), 1);
        chk("acc_lat_syn", int'(c_synapse_index_o), 5);
        goto(a + 40); settle();
        chk("acc5_cycles", acc5_cnt, 32);

        // Ten back-to-back events during a sweep
        dut_ev.delete();
        send(100, 10, a);
        goto(a + 4);
        for (int i = 0; i < 10; i++) begin
            ev[i] = $urandom_range(200, 16383);
            send(ev[i], 100, t[i]);
        end
        chk("ack8_spacing", t[7] - t[0], 7);
        chk("ack9_blocked", t[8] - t[0], 31);
        chk("ack10_blocked", t[9] - t[8], 33);
        goto(a + 400); settle();
        chk("ev_count", dut_ev.size(), 11);
        if (dut_ev.size() == 11) begin
            chk("ev_order_0", dut_ev[0], 100);
            for (int i = 0; i < 10; i++) chk("ev_order", dut_ev[i+1], ev[i]);
        end

        // Two steps during one sweep
        fire_cnt = 0;
        send(33, 10, a);
        goto(a + 6);
        pulse_step();
        goto(a + 11);
        pulse_step();
        goto(a + 80); settle();
        chk("overrun_set", int'(step_overrun_o), 1);
        chk("one_update_pass", fire_cnt, 16);
        chk("ts_after_overrun", int'(timestep_o), 2);

        // Run to the last timestep
        fire_cnt = 0;
        s = cyc;
        goto(s + 1);
        pulse_step();
        goto(s + 45); settle();
        chk("ts_3", int'(timestep_o), 3);
        goto(s + 46);
        pulse_step();
        goto(s + 90); settle();
        chk("done_set", int'(done_o), 1);
        chk("busy_clear", int'(busy_o), 0);
        chk("ts_hold", int'(timestep_o), 3);
        chk("fire_count_2", fire_cnt, 32);
        goto(s + 91);
        pulse_start();
        settle();
        chk("restart_done", int'(done_o), 0);
        chk("restart_ts", int'(timestep_o), 0);
        chk("restart_ovr", int'(step_overrun_o), 0);
        chk("restart_busy", int'(busy_o), 1);

        // Reset during an accumulate write cycle
        send(9, 10, a);
        k = 0;
        while (!(m_mode == 2 && m_pos % 2 == 1) && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        chk("found_acc_wr", int'(c_neuron_we_o && c_accumulate_o), 1);
        reset_i = 1'b1;
        settle();
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_acc", int'(c_accumulate_o), 0);
        chk("midrst_we", int'(c_neuron_we_o), 0);
        chk("midrst_syn", int'(c_synapse_index_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        occ = 1'b1; idx = 14'd3;
        repeat (5) begin
            settle();
            chk("ack_after_reset", int'(input_ack_o), 0);
            @(negedge clk_i);
        end
        pulse_start();
        settle();
        chk("ack_after_start", int'(input_ack_o), 1);
        @(negedge clk_i);
        occ = 1'b0;

        // Randomized traffic
        acked = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            reset_i = ($urandom % 800 == 0);
            start_i = ($urandom % 60 == 0);
            step_i  = ($urandom % 45 == 0);
            if (!occ || acked) begin
                occ = ($urandom % 3 == 0);
                idx = 14'($urandom_range(0, 16383));
            end
            #1 acked = input_ack_o;
        end
        @(negedge clk_i);
        reset_i = 1'b0; start_i = 1'b0; step_i = 1'b0; occ = 1'b0;
        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
